// File: rtl/probe_seq.sv
// probe_seq: turns one AXI byte read/write request into a UART probe command stream and returns one response
// ports: clk, m_aresetn (async, active low)
//        req_valid/req_ready/req_write/req_addr/req_wdata/req_ae   request in
//        cmd_valid/cmd_data/cmd_ready                               command bytes to probe rx
//        probe_tx_valid/probe_tx_data/probe_tx_ready                reply bytes from probe tx
//        rsp_valid/rsp_ready/rsp_rdata/rsp_resp/rsp_err             response out
module probe_seq #(
  parameter int POLL_LIMIT = 16,
  parameter int WAIT_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        m_aresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        req_ae,
  output logic        cmd_valid,
  output logic [7:0]  cmd_data,
  input  logic        cmd_ready,
  input  logic        probe_tx_valid,
  input  logic [7:0]  probe_tx_data,
  output logic        probe_tx_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_err
);
  typedef enum logic [3:0] {
    IDLE, ADDR_CMD, ADDR_DAT, CTRL_CMD, CTRL_DAT, WDAT_CMD, WDAT_DAT,
    POLL_CMD, POLL_WAIT, RD_CMD, RD_WAIT, RESP
  } state_t;
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [PW-1:0] PMAX = PW'(POLL_LIMIT - 1);
  localparam logic [WW-1:0] WMAX = WW'(WAIT_LIMIT - 1);
  state_t st, st_n;
  logic wr_r, ae_r, err_n, cmd_fire, rx_fire, done, poll_last, wait_last;
  logic [31:0] a_r, sh;
  logic [7:0] wd_r;
  logic [3:0] sh_v, need, need_req;
  logic [1:0] idx;
  logic [PW-1:0] poll_cnt;
  logic [WW-1:0] wait_cnt;
  // an address byte must be sent unless the probe is known to already hold it
  function automatic logic [3:0] need_f(input logic [31:0] a, input logic [31:0] s, input logic [3:0] v);
    for (int n = 0; n < 4; n++) need_f[n] = !v[n] || (s[8*n +: 8] != a[8*n +: 8]);
  endfunction
  assign need_req = need_f(req_addr, sh, sh_v);
  assign need = need_f(a_r, sh, sh_v);
  assign idx = need[0] ? 2'd0 : need[1] ? 2'd1 : need[2] ? 2'd2 : 2'd3;
  assign req_ready = st == IDLE;
  assign rsp_valid = st == RESP;
  assign probe_tx_ready = st == POLL_WAIT || st == RD_WAIT;
  assign cmd_valid = st inside {ADDR_CMD, ADDR_DAT, CTRL_CMD, CTRL_DAT, WDAT_CMD, WDAT_DAT, POLL_CMD, RD_CMD};
  assign cmd_fire = cmd_valid && cmd_ready;
  assign rx_fire = probe_tx_ready && probe_tx_valid;
  assign done = wr_r ? probe_tx_data[2] : probe_tx_data[3];
  assign poll_last = poll_cnt == PMAX;
  assign wait_last = probe_tx_ready && !probe_tx_valid && wait_cnt == WMAX;
  always_comb begin
    case (st)
      ADDR_CMD: cmd_data = 8'h12 + {6'b0, idx};
      ADDR_DAT: cmd_data = a_r[8*idx +: 8];
      CTRL_CMD: cmd_data = 8'h19;
      CTRL_DAT: cmd_data = {6'b0, ae_r, ~wr_r};
      WDAT_CMD: cmd_data = 8'h17;
      WDAT_DAT: cmd_data = wd_r;
      POLL_CMD: cmd_data = 8'h18;
      RD_CMD:   cmd_data = 8'h16;
      default:  cmd_data = 8'h00;
    endcase
  end
  always_comb begin
    st_n = st;
    err_n = 1'b0;
    case (st)
      IDLE:     if (req_valid) st_n = |need_req ? ADDR_CMD : CTRL_CMD;
      ADDR_CMD: if (cmd_fire) st_n = ADDR_DAT;
      ADDR_DAT: if (cmd_fire) st_n = |(need & ~(4'b1 << idx)) ? ADDR_CMD : CTRL_CMD;
      CTRL_CMD: if (cmd_fire) st_n = CTRL_DAT;
      CTRL_DAT: if (cmd_fire) st_n = wr_r ? WDAT_CMD : POLL_CMD;
      WDAT_CMD: if (cmd_fire) st_n = WDAT_DAT;
      WDAT_DAT: if (cmd_fire) st_n = POLL_CMD;
      POLL_CMD: if (cmd_fire) st_n = POLL_WAIT;
      POLL_WAIT: begin
        if (rx_fire) begin
          st_n = done ? (wr_r ? RESP : RD_CMD) : poll_last ? RESP : POLL_CMD;
          err_n = !done && poll_last;
        end else if (wait_last) begin
          st_n = RESP;
          err_n = 1'b1;
        end
      end
      RD_CMD:   if (cmd_fire) st_n = RD_WAIT;
      RD_WAIT: begin
        st_n = (rx_fire || wait_last) ? RESP : RD_WAIT;
        err_n = !rx_fire && wait_last;
      end
      RESP:     if (rsp_ready) st_n = IDLE;
      default:  st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      st <= IDLE;
      wr_r <= 1'b0;
      ae_r <= 1'b0;
      a_r <= '0;
      wd_r <= '0;
      sh <= '0;
      sh_v <= '0;
      poll_cnt <= '0;
      wait_cnt <= '0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
      rsp_err <= 1'b0;
    end else begin
      st <= st_n;
      if (st == IDLE && req_valid) begin
        wr_r <= req_write;
        ae_r <= req_ae;
        a_r <= req_addr;
        wd_r <= req_wdata;
        poll_cnt <= '0;
        rsp_rdata <= '0;
        rsp_resp <= '0;
      end
      if (st == ADDR_DAT && cmd_fire) begin
        sh[8*idx +: 8] <= a_r[8*idx +: 8];
        sh_v[idx] <= 1'b1;
      end
      if (st == POLL_WAIT && rx_fire) begin
        if (done) rsp_resp <= wr_r ? probe_tx_data[5:4] : probe_tx_data[7:6];
        else if (!poll_last) poll_cnt <= poll_cnt + 1'b1;
      end
      if (st == RD_WAIT && rx_fire) rsp_rdata <= probe_tx_data;
      wait_cnt <= !probe_tx_ready ? '0 : (wait_cnt == WMAX ? wait_cnt : wait_cnt + 1'b1);
      if (err_n) rsp_err <= 1'b1;
      else if (st == RESP && rsp_ready) rsp_err <= 1'b0;
      // after an error or an auto-incrementing access the probe's address is unknown
      if (err_n || (st != RESP && st_n == RESP && ae_r)) sh_v <= '0;
    end
  end
endmodule
